mixcolumns_engine: RTL and testbench

Sequential, parametrised AES MixColumns unit that transforms a full 128-bit state, four 32-bit columns, in either forward or inverse mode. It sits between the ShiftRows and AddRoundKey stages of the round datapath and replaces per-column combinational instances. Throughput and area are traded through `COLS_PER_CYCLE`. Data moves over valid/ready handshakes on both sides.

---
 rtl/mixcolumns_engine.sv | 177 +++++++++++++++++
 tb/tb_mixcolumns_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mixcolumns_engine.sv
// mixcolumns_engine: sequential AES (Inv)MixColumns over a 128-bit state.
// COLS_PER_CYCLE columns are transformed per BUSY cycle (1, 2 or 4).
// Optional feature macro: AES_MIXCOL_FWD_EN -- when defined, both forward and
// inverse matrices are built and in_inv selects; when undefined only the
// inverse matrix exists and every transform is InvMixColumns.

// One column through the MixColumns matrix, built from xtime chains.
module mixcol_unit (
`ifdef AES_MIXCOL_FWD_EN
  input  logic        inv,
`endif
  input  logic [31:0] col,
  output logic [31:0] res
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];

  // Split rows and build the doubling chain for every byte.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2[r] = xt(a[r]);
      x4[r] = xt(x2[r]);
      x8[r] = xt(x4[r]);
    end
  end

  // Combine the multiples: 09=8+1, 0b=8+2+1, 0d=8+4+1, 0e=8+4+2, 03=2+1.
  always_comb begin
    res = '0;
    for (int r = 0; r < 4; r++) begin
      logic [1:0] r1, r2, r3;
      logic [7:0] ib, fb;
      r1 = 2'(r + 1);
      r2 = 2'(r + 2);
      r3 = 2'(r + 3);
      ib = (x8[r] ^ x4[r] ^ x2[r])
         ^ (x8[r1] ^ x2[r1] ^ a[r1])
         ^ (x8[r2] ^ x4[r2] ^ a[r2])
         ^ (x8[r3] ^ a[r3]);
`ifdef AES_MIXCOL_FWD_EN
      fb = x2[r] ^ (x2[r1] ^ a[r1]) ^ a[r2] ^ a[r3];
      res[31-8*r -: 8] = inv ? ib : fb;
`else
      fb = 8'h00;
      res[31-8*r -: 8] = ib ^ fb;
`endif
    end
  end
endmodule

module mixcolumns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);
  localparam int C      = COLS_PER_CYCLE;
  localparam int GROUPS = 4 / C;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  generate
    if (C != 1 && C != 2 && C != 4) begin : g_bad_cfg
      $error("mixcolumns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            last_grp;
  logic [0:3][31:0] work, work_nxt;   // index 0 is column 0 = [127:96]
  logic [127:0]    out_q;
  logic [1:0]      col_idx [C];
  logic [31:0]     col_in  [C];
  logic [31:0]     col_res [C];

`ifdef AES_MIXCOL_FWD_EN
  logic            inv_q;
`else
  logic            unused_inv;
  assign unused_inv = in_inv;
`endif

  assign last_grp = (cnt == CW'(GROUPS - 1));

  // Columns handled in this cycle: cnt*C .. cnt*C+C-1.
  always_comb begin
    for (int g = 0; g < C; g++) begin
      col_idx[g] = 2'(int'(cnt) * C + g);
      col_in[g]  = work[col_idx[g]];
    end
  end

  for (genvar g = 0; g < C; g++) begin : g_lane
    mixcol_unit u_col (
`ifdef AES_MIXCOL_FWD_EN
      .inv (inv_q),
`endif
      .col (col_in[g]),
      .res (col_res[g])
    );
  end

  // Working register with this cycle's columns written back in place.
  always_comb begin
    work_nxt = work;
    for (int g = 0; g < C; g++) work_nxt[col_idx[g]] = col_res[g];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last_grp)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // FSM outputs; no accept while reset is held.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Datapath: capture on accept, transform in place, publish on last group.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      work  <= '0;
      out_q <= '0;
`ifdef AES_MIXCOL_FWD_EN
      inv_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work  <= in_state;
          cnt   <= '0;
`ifdef AES_MIXCOL_FWD_EN
          inv_q <= in_inv;
`endif
        end
        BUSY: begin
          work <= work_nxt;
          cnt  <= last_grp ? '0 : cnt + 1'b1;
          if (last_grp) out_q <= work_nxt;
        end
        default: ;
      endcase
    end
  end

  assign out_state = out_q;
endmodule

// File: tb/tb_mixcolumns_engine.sv
// Scoreboard bench for mixcolumns_engine: three instances (C=1,2,4) checked
// against a GF(2^8) matrix-product reference model.
module tb_mixcolumns_engine;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         in_inv    [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [127:0] exp_q [3][$];

  localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    mixcolumns_engine #(.COLS_PER_CYCLE(1 << i)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[i]),
      .in_ready  (in_ready[i]),
      .in_state  (in_state[i]),
      .in_inv    (in_inv[i]),
      .out_valid (out_valid[i]),
      .out_ready (out_ready[i]),
      .out_state (out_state[i])
    );

    // Monitor: every handoff pops one expected result.
    always @(negedge clk) begin
      logic [127:0] e;
      if (!rst && out_valid[i] && out_ready[i]) begin
        if (exp_q[i].size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output dut%0d: got %h with nothing pending", i, out_state[i]);
        end else begin
          e = exp_q[i].pop_front();
          chk($sformatf("out_state dut%0d", i), out_state[i], e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain polynomial product reduced modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] mc_raw(input logic [127:0] st, input logic inv);
    logic [7:0] co [4];
    logic [7:0] a  [4];
    logic [7:0] o;
    logic [127:0] r = '0;
    if (inv) begin co[0] = 8'h0e; co[1] = 8'h0b; co[2] = 8'h0d; co[3] = 8'h09; end
    else     begin co[0] = 8'h02; co[1] = 8'h03; co[2] = 8'h01; co[3] = 8'h01; end
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = st[127-32*c-8*k -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        o = 8'h00;
        for (int k = 0; k < 4; k++) o = o ^ gmul(co[(k - rr + 4) % 4], a[k]);
        r[127-32*c-8*rr -: 8] = o;
      end
    end
    return r;
  endfunction

  // What the build is expected to do for a requested mode.
  function automatic logic [127:0] mc_ref(input logic [127:0] st, input logic inv);
`ifdef AES_MIXCOL_FWD_EN
    return mc_raw(st, inv);
`else
    return mc_raw(st, 1'b1 | inv);
`endif
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present a state, wait for the accept edge, push the expected result.
  task automatic send(input int d, input logic [127:0] st, input logic inv,
                      input logic [127:0] exp, output int t_acc);
    int n = 0;
    in_state[d] = st; in_inv[d] = inv; in_valid[d] = 1'b1;
    while (!in_ready[d] && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready[d]) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d: in_ready stayed 0 for %0d cycles", d, n);
      in_valid[d] = 1'b0; t_acc = -1;
      return;
    end
    @(posedge clk); #1;
    exp_q[d].push_back(exp);
    t_acc = cyc;
    in_valid[d] = 1'b0;
    in_state[d] = rnd128();   // latched copy must be used, not the live bus
  endtask

  task automatic wait_out(input int d, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic wait_drain(input int d);
    int n = 0;
    while (exp_q[d].size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    if (exp_q[d].size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout dut%0d: %0d results still pending", d, exp_q[d].size());
    end
  endtask

  initial begin
    int t, tp, lat;
    logic [127:0] x, e;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_state[i] = '0; in_inv[i] = 1'b0; out_ready[i] = 1'b1;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset in_ready dut%0d", i), 128'(in_ready[i]), 128'(0));
      chk($sformatf("reset out_valid dut%0d", i), 128'(out_valid[i]), 128'(0));
      chk($sformatf("reset out_state dut%0d", i), out_state[i], '0);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("post-reset in_ready dut%0d", i), 128'(in_ready[i]), 128'(1));

    // Forward vector, C=1, latency 4.
`ifdef AES_MIXCOL_FWD_EN
    e = V1_OUT;
`else
    e = mc_ref(V1_IN, 1'b0);
`endif
    send(0, V1_IN, 1'b0, e, t);
    wait_out(0, lat);
    chk("latency C=1", 128'(lat), 128'(4));
    wait_drain(0);

    // Inverse vector, C=2, latency 2.
    send(1, V1_OUT, 1'b1, V1_IN, t);
    wait_out(1, lat);
    chk("latency C=2", 128'(lat), 128'(2));
    wait_drain(1);

    // Backpressure, C=4.
    out_ready[2] = 1'b0;
    x = rnd128();
    e = mc_ref(x, 1'b1);
    send(2, x, 1'b1, e, t);
    wait_out(2, lat);
    chk("latency C=4", 128'(lat), 128'(1));
    in_valid[2] = 1'b1; in_state[2] = rnd128(); in_inv[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall out_valid cyc%0d", k), 128'(out_valid[2]), 128'(1));
      chk($sformatf("stall out_state cyc%0d", k), out_state[2], e);
      chk($sformatf("stall in_ready cyc%0d", k), 128'(in_ready[2]), 128'(0));
    end
    in_valid[2] = 1'b0;
    out_ready[2] = 1'b1;
    @(posedge clk); #1;
    chk("handoff out_valid", 128'(out_valid[2]), 128'(0));
    chk("handoff in_ready", 128'(in_ready[2]), 128'(1));
    chk("handoff count", 128'(exp_q[2].size()), 128'(0));

    // Reset during the second BUSY cycle, C=1.
    send(0, rnd128(), 1'b1, '0, t);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q[0].delete();
    chk("rst-mid out_valid", 128'(out_valid[0]), 128'(0));
    chk("rst-mid out_state", out_state[0], '0);
    chk("rst-mid in_ready held", 128'(in_ready[0]), 128'(0));
    rst = 1'b0;
    #1;
    chk("rst-mid in_ready after", 128'(in_ready[0]), 128'(1));
    send(0, V1_IN, 1'b0, mc_ref(V1_IN, 1'b0), t);
    wait_drain(0);

    // Mode latched at accept; toggling in_inv while BUSY has no effect.
    x = rnd128();
    send(0, x, 1'b1, mc_ref(x, 1'b1), t);
    in_inv[0] = 1'b0;
    @(posedge clk); #1; in_inv[0] = 1'b1;
    @(posedge clk); #1; in_inv[0] = 1'b0;
    wait_drain(0);

    // Back-to-back traffic with round trip, C=1.
    out_ready[0] = 1'b1;
    tp = -1;
    for (int k = 0; k < 8; k++) begin
      x = rnd128();
      send(0, x, 1'b0, mc_ref(x, 1'b0), t);
      if (tp >= 0) chk($sformatf("spacing fwd %0d", k), 128'(t - tp), 128'(6));
      tp = t;
      send(0, mc_raw(x, 1'b0), 1'b1, x, t);
      chk($sformatf("spacing inv %0d", k), 128'(t - tp), 128'(6));
      tp = t;
    end
    wait_drain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
